// File: rtl/side_buf_reinject_pkg.sv
// Shared types and defaults for the MinBD side buffer: the internal flit format,
// channel count, buffer sizing and the re-inject FSM states.
package side_buf_reinject_pkg;

    localparam int NUM_CHNL                = 4;
    localparam int DEFAULT_DEPTH           = 4;
    localparam int DEFAULT_REDIRECT_THRESH = 8;
    localparam int DST_W                   = 4;
    localparam int PAYLOAD_W               = 16;

    typedef struct packed {
        logic                 valid;
        logic                 deflect;
        logic [DST_W-1:0]     dst;
        logic [PAYLOAD_W-1:0] payload;
    } flit_int_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_REDIRECT
    } sb_state_t;

    // Channel index arithmetic wraps naturally because NUM_CHNL is 4.
    function automatic logic [1:0] chan_add(input logic [1:0] base, input logic [1:0] off);
        return base + off;
    endfunction

    function automatic flit_int_t clear_deflect(input flit_int_t f);
        flit_int_t r;
        r         = f;
        r.deflect = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/side_buf_reinject_if.sv
// Channel and side-buffer bundle between the eject stage, the side buffer and the crossbar.
// The slave modport is the side buffer's view; master is the surrounding router (or a bench).
interface side_buf_reinject_if
    import side_buf_reinject_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
);

    logic [1:0]            rand_num;
    flit_int_t             din_0;
    flit_int_t             din_1;
    flit_int_t             din_2;
    flit_int_t             din_3;
    flit_int_t             side_buf_din;
    logic                  side_buf_wr;
    flit_int_t             dout_0;
    flit_int_t             dout_1;
    flit_int_t             dout_2;
    flit_int_t             dout_3;
    logic                  full;
    logic                  empty;
    logic                  redirect_gnt;
    logic                  reinject_vld;
    logic [$clog2(DEPTH):0] occupancy;

    modport slave (
        input  rand_num,
        input  din_0,
        input  din_1,
        input  din_2,
        input  din_3,
        input  side_buf_din,
        input  side_buf_wr,
        output dout_0,
        output dout_1,
        output dout_2,
        output dout_3,
        output full,
        output empty,
        output redirect_gnt,
        output reinject_vld,
        output occupancy
    );

    modport master (
        output rand_num,
        output din_0,
        output din_1,
        output din_2,
        output din_3,
        output side_buf_din,
        output side_buf_wr,
        input  dout_0,
        input  dout_1,
        input  dout_2,
        input  dout_3,
        input  full,
        input  empty,
        input  redirect_gnt,
        input  reinject_vld,
        input  occupancy
    );

endinterface

// File: rtl/side_buf_reinject_fifo.sv
// Circular flit store for the side buffer with a combinational head and registered full/empty.
// A push while full is only legal together with a pop (the redirect swap).
module side_buf_reinject_fifo
    import side_buf_reinject_pkg::*;
#(
    parameter int  DEPTH = DEFAULT_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  flit_int_t        push_data,
    input  logic             pop,
    output flit_int_t        head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next
);

    flit_int_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    assign head = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // Storage is not reset: only entries between rd_ptr and wr_ptr are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assert property (@(posedge clk) disable iff (reset) !(pop && empty))
        else $error("side_buf_reinject_fifo: pop while empty");

    assert property (@(posedge clk) disable iff (reset) !(push && full && !pop))
        else $error("side_buf_reinject_fifo: push while full without pop");

endmodule

// File: rtl/side_buf_reinject.sv
// MinBD side buffer receive end: buffers deflected flits, re-injects them into free channel
// slots and, when the head has starved too long, swaps it into an occupied slot.
module side_buf_reinject
    import side_buf_reinject_pkg::*;
#(
    parameter int  DEPTH           = DEFAULT_DEPTH,
    parameter int  REDIRECT_THRESH = DEFAULT_REDIRECT_THRESH,
    localparam int CNT_W           = $clog2(DEPTH) + 1,
    localparam int WAIT_W          = $clog2(REDIRECT_THRESH + 1)
) (
    input logic                clk,
    input logic                reset,
    side_buf_reinject_if.slave bus
);

    flit_int_t         din  [NUM_CHNL];
    flit_int_t         dout [NUM_CHNL];
    flit_int_t         head;
    flit_int_t         push_data;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              swap;
    logic              free_found;
    logic              redirect_gnt;
    logic [1:0]        free_idx;
    logic [1:0]        place_idx;
    logic [1:0]        cand;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [WAIT_W-1:0] wait_cnt;
    sb_state_t         state;
    sb_state_t         state_next;

    assign din[0] = bus.din_0;
    assign din[1] = bus.din_1;
    assign din[2] = bus.din_2;
    assign din[3] = bus.din_3;

    assign bus.dout_0       = dout[0];
    assign bus.dout_1       = dout[1];
    assign bus.dout_2       = dout[2];
    assign bus.dout_3       = dout[3];
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.redirect_gnt = redirect_gnt;
    assign bus.reinject_vld = pop;
    assign bus.occupancy    = count;

    assign redirect_gnt = (state == ST_REDIRECT);

    side_buf_reinject_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .count_next (count_next)
    );

    // Rotating search starting at rand_num so no channel is systematically favoured.
    always_comb begin
        free_found = 1'b0;
        free_idx   = 2'd0;
        cand       = 2'd0;
        for (int i = 0; i < NUM_CHNL; i++) begin
            cand = chan_add(bus.rand_num, 2'(i));
            if (!free_found && !din[cand].valid) begin
                free_found = 1'b1;
                free_idx   = cand;
            end
        end
    end

    // A free slot always wins; the swap into the rand_num victim only happens when none exists.
    always_comb begin
        pop       = 1'b0;
        swap      = 1'b0;
        place_idx = free_idx;
        if (!empty) begin
            if (free_found) begin
                pop = 1'b1;
            end else if (redirect_gnt) begin
                pop       = 1'b1;
                swap      = 1'b1;
                place_idx = bus.rand_num;
            end
        end
    end

    assign push      = (bus.side_buf_wr && !full) || swap;
    assign push_data = swap ? din[place_idx] : bus.side_buf_din;

    always_comb begin
        for (int k = 0; k < NUM_CHNL; k++) begin
            dout[k] = din[k];
        end
        if (pop) begin
            dout[place_idx] = clear_deflect(head);
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (count_next != '0) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (count_next == '0) begin
                    state_next = ST_IDLE;
                end else if (wait_cnt == WAIT_W'(REDIRECT_THRESH) && !free_found) begin
                    state_next = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                state_next = (count_next != '0) ? ST_WAIT : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Starvation age of the current head; saturates so the redirect condition stays armed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (pop || empty) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_W'(REDIRECT_THRESH)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    assert property (@(posedge clk) disable iff (reset) !(redirect_gnt && bus.side_buf_wr))
        else $error("side_buf_reinject: side_buf_wr asserted during redirect_gnt");

    assert property (@(posedge clk) disable iff (reset) redirect_gnt |=> !redirect_gnt)
        else $error("side_buf_reinject: redirect lasted more than one cycle");

endmodule

// File: tb/tb_side_buf_reinject.sv
// Scoreboard bench for side_buf_reinject: a queue-based reference model predicts every cycle's
// outputs, a separate monitor compares them; directed scenarios are followed by random traffic.
module tb_side_buf_reinject;
    import side_buf_reinject_pkg::*;

    localparam int DEPTH  = 4;
    localparam int THRESH = 8;

    typedef struct packed {
        flit_int_t [NUM_CHNL-1:0] dout;
        logic                     reinj;
        logic                     redir;
        logic [$clog2(DEPTH):0]   occ;
        logic                     full;
        logic                     empty;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    side_buf_reinject_if #(.DEPTH(DEPTH)) bus ();

    side_buf_reinject #(
        .DEPTH           (DEPTH),
        .REDIRECT_THRESH (THRESH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int        total = 0;
    int        bad   = 0;
    exp_t      exp_q [$];
    flit_int_t model_q [$];
    int        model_wait  = 0;
    bit        model_redir = 1'b0;

    flit_int_t  stim_din [NUM_CHNL];
    flit_int_t  stim_sbd;
    logic       stim_wr;
    logic [1:0] stim_rand;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic flit_int_t make_flit(input logic v, input logic defl);
        flit_int_t f;
        f.valid   = v;
        f.deflect = defl;
        f.dst     = DST_W'($urandom);
        f.payload = PAYLOAD_W'($urandom);
        return f;
    endfunction

    task automatic set_channels(input logic [3:0] free_mask);
        for (int k = 0; k < NUM_CHNL; k++) begin
            stim_din[k] = make_flit(!free_mask[k], 1'($urandom_range(0, 1)));
        end
    endtask

    // Drive one cycle, predict its outputs from the queue model, then advance the model past the edge.
    task automatic apply_stimulus();
        exp_t      e;
        flit_int_t hd;
        int        free;
        int        slot;
        int        size_before;
        bit        full_before;
        bit        popped;
        bit        redir_next;
        @(negedge clk);
        if (model_redir) stim_wr = 1'b0;
        bus.din_0        = stim_din[0];
        bus.din_1        = stim_din[1];
        bus.din_2        = stim_din[2];
        bus.din_3        = stim_din[3];
        bus.rand_num     = stim_rand;
        bus.side_buf_wr  = stim_wr;
        bus.side_buf_din = stim_sbd;

        for (int k = 0; k < NUM_CHNL; k++) e.dout[k] = stim_din[k];
        free = -1;
        for (int i = 0; i < NUM_CHNL; i++) begin
            int ch;
            ch = (int'(stim_rand) + i) % NUM_CHNL;
            if (free < 0 && !stim_din[ch].valid) free = ch;
        end
        size_before = model_q.size();
        full_before = (size_before == DEPTH);
        e.occ   = ($clog2(DEPTH)+1)'(size_before);
        e.full  = full_before;
        e.empty = (size_before == 0);
        e.redir = model_redir;
        e.reinj = 1'b0;
        popped  = 1'b0;
        if (size_before > 0 && (free >= 0 || model_redir)) begin
            slot       = (free >= 0) ? free : int'(stim_rand);
            hd         = model_q.pop_front();
            hd.deflect = 1'b0;
            e.dout[slot] = hd;
            e.reinj    = 1'b1;
            popped     = 1'b1;
            if (free < 0) model_q.push_back(stim_din[stim_rand]);
        end
        if (stim_wr && !full_before) model_q.push_back(stim_sbd);
        redir_next  = !model_redir && size_before > 0 && model_wait == THRESH && free < 0;
        model_wait  = (popped || size_before == 0) ? 0 : ((model_wait < THRESH) ? model_wait + 1 : THRESH);
        model_redir = redir_next;
        exp_q.push_back(e);
    endtask

    task automatic check_output(input exp_t e);
        flit_int_t act [NUM_CHNL];
        act[0] = bus.dout_0;
        act[1] = bus.dout_1;
        act[2] = bus.dout_2;
        act[3] = bus.dout_3;
        for (int k = 0; k < NUM_CHNL; k++) begin
            check($sformatf("dout_%0d", k), 32'(act[k]), 32'(e.dout[k]));
        end
        check("reinject_vld", 32'(bus.reinject_vld), 32'(e.reinj));
        check("redirect_gnt", 32'(bus.redirect_gnt), 32'(e.redir));
        check("occupancy",    32'(bus.occupancy),    32'(e.occ));
        check("full",         32'(bus.full),         32'(e.full));
        check("empty",        32'(bus.empty),        32'(e.empty));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output(e);
            end
        end
    end

    initial begin : stimulus
        flit_int_t flit_a;
        flit_int_t victim;
        flit_int_t exp_f;
        flit_int_t act;
        int        dens;

        reset     = 1'b1;
        stim_wr   = 1'b0;
        stim_rand = 2'd0;
        stim_sbd  = make_flit(1'b1, 1'b1);
        set_channels(4'b0000);
        bus.din_0        = stim_din[0];
        bus.din_1        = stim_din[1];
        bus.din_2        = stim_din[2];
        bus.din_3        = stim_din[3];
        bus.rand_num     = 2'd0;
        bus.side_buf_wr  = 1'b0;
        bus.side_buf_din = stim_sbd;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        $display("[TB] idle pass-through after reset");
        set_channels(4'b0000);
        apply_stimulus();
        #2;
        check("idle_dout_0", 32'(bus.dout_0), 32'(stim_din[0]));
        check("idle_empty",  32'(bus.empty), 32'd1);
        check("idle_full",   32'(bus.full), 32'd0);
        check("idle_gnt",    32'(bus.redirect_gnt), 32'd0);

        $display("[TB] single push then free slot");
        flit_a    = make_flit(1'b1, 1'b1);
        set_channels(4'b0000);
        stim_wr   = 1'b1;
        stim_sbd  = flit_a;
        stim_rand = 2'd0;
        apply_stimulus();
        set_channels(4'b0100);
        stim_wr   = 1'b0;
        stim_rand = 2'd1;
        apply_stimulus();
        #2;
        exp_f = flit_a;
        exp_f.deflect = 1'b0;
        check("push_reinject_dout_2", 32'(bus.dout_2), 32'(exp_f));
        check("push_reinject_vld",    32'(bus.reinject_vld), 32'd1);
        set_channels(4'b0000);
        apply_stimulus();
        #2;
        check("push_empty_after", 32'(bus.empty), 32'd1);

        $display("[TB] fill and drop");
        for (int i = 0; i < 5; i++) begin
            set_channels(4'b0000);
            stim_wr   = 1'b1;
            stim_sbd  = make_flit(1'b1, 1'b1);
            stim_rand = 2'(i);
            apply_stimulus();
        end
        #2;
        check("fill_full", 32'(bus.full), 32'd1);
        check("fill_occ",  32'(bus.occupancy), 32'd4);
        set_channels(4'b0000);
        stim_wr = 1'b0;
        apply_stimulus();
        #2;
        check("fill_drop_occ", 32'(bus.occupancy), 32'd4);
        repeat (4) begin
            set_channels(4'b1111);
            stim_rand = 2'($urandom_range(0, 3));
            apply_stimulus();
        end

        $display("[TB] simultaneous push and pop across wrap");
        repeat (2) begin
            set_channels(4'b0000);
            stim_wr  = 1'b1;
            stim_sbd = make_flit(1'b1, 1'b1);
            apply_stimulus();
        end
        for (int i = 0; i < 6; i++) begin
            set_channels(4'(4'b0001 << (i % 4)));
            stim_wr   = 1'b1;
            stim_sbd  = make_flit(1'b1, 1'b1);
            stim_rand = 2'($urandom_range(0, 3));
            apply_stimulus();
        end
        #2;
        check("pp_occ", 32'(bus.occupancy), 32'd2);
        set_channels(4'b0000);
        stim_wr = 1'b0;
        apply_stimulus();
        #2;
        check("pp_occ_hold", 32'(bus.occupancy), 32'd2);
        repeat (2) begin
            set_channels(4'b1111);
            apply_stimulus();
        end

        $display("[TB] starvation redirect");
        flit_a    = make_flit(1'b1, 1'b1);
        set_channels(4'b0000);
        stim_wr   = 1'b1;
        stim_sbd  = flit_a;
        stim_rand = 2'd3;
        apply_stimulus();
        stim_wr = 1'b0;
        repeat (9) begin
            set_channels(4'b0000);
            apply_stimulus();
        end
        set_channels(4'b0000);
        victim = stim_din[3];
        apply_stimulus();
        #2;
        exp_f = flit_a;
        exp_f.deflect = 1'b0;
        check("starve_gnt",    32'(bus.redirect_gnt), 32'd1);
        check("starve_dout_3", 32'(bus.dout_3), 32'(exp_f));
        check("starve_occ",    32'(bus.occupancy), 32'd1);
        set_channels(4'b0100);
        stim_rand = 2'd2;
        apply_stimulus();
        #2;
        exp_f = victim;
        exp_f.deflect = 1'b0;
        check("starve_gnt_once",   32'(bus.redirect_gnt), 32'd0);
        check("starve_victim_out", 32'(bus.dout_2), 32'(exp_f));

        $display("[TB] async reset mid-wait");
        repeat (3) begin
            set_channels(4'b0000);
            stim_wr  = 1'b1;
            stim_sbd = make_flit(1'b1, 1'b1);
            apply_stimulus();
        end
        set_channels(4'b0000);
        stim_wr = 1'b0;
        apply_stimulus();
        #3;
        reset           = 1'b1;
        bus.side_buf_wr = 1'b0;
        #1;
        check("rst_occ",   32'(bus.occupancy), 32'd0);
        check("rst_gnt",   32'(bus.redirect_gnt), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full",  32'(bus.full), 32'd0);
        for (int k = 0; k < NUM_CHNL; k++) begin
            case (k)
                0:       act = bus.dout_0;
                1:       act = bus.dout_1;
                2:       act = bus.dout_2;
                default: act = bus.dout_3;
            endcase
            check($sformatf("rst_pass_%0d", k), 32'(act), 32'(stim_din[k]));
        end
        model_q.delete();
        model_wait  = 0;
        model_redir = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] random traffic");
        dens = 0;
        for (int c = 0; c < 400; c++) begin
            if (c % 25 == 0) dens = $urandom_range(0, 2);
            for (int k = 0; k < NUM_CHNL; k++) begin
                logic v;
                if (dens == 2)      v = 1'b1;
                else if (dens == 1) v = ($urandom_range(0, 9) != 0);
                else                v = 1'($urandom_range(0, 1));
                stim_din[k] = make_flit(v, 1'($urandom_range(0, 1)));
            end
            stim_rand = 2'($urandom_range(0, 3));
            stim_wr   = ($urandom_range(0, 9) < 6);
            stim_sbd  = make_flit(1'b1, 1'b1);
            apply_stimulus();
        end

        @(negedge clk);
        #3;
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
